// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - tag-based reservation station with result snooping and locked issue selection
module reservation_station #(
    parameter int RS_ID_WIDTH = 5,
    parameter int ENTRIES     = 3,
    parameter int RS_BASE_ID  = 0,
    parameter int OP_WIDTH    = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dispatch_valid,
    output logic                   dispatch_ready,
    input  logic [OP_WIDTH-1:0]    dispatch_op,
    input  logic                   dispatch_a_valid,
    input  logic [31:0]            dispatch_a_value,
    input  logic [RS_ID_WIDTH-1:0] dispatch_a_rs_id,
    input  logic                   dispatch_b_valid,
    input  logic [31:0]            dispatch_b_value,
    input  logic [RS_ID_WIDTH-1:0] dispatch_b_rs_id,
    output logic [RS_ID_WIDTH-1:0] dispatch_rs_id,
    input  logic                   result_valid,
    input  logic [RS_ID_WIDTH-1:0] result_rs_id,
    input  logic [31:0]            result_value,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [OP_WIDTH-1:0]    issue_op,
    output logic [31:0]            issue_a,
    output logic [31:0]            issue_b,
    output logic [RS_ID_WIDTH-1:0] issue_rs_id
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef enum logic [1:0] {
        ST_FREE    = 2'd0,
        ST_WAITING = 2'd1,
        ST_ISSUED  = 2'd2
    } entry_state_t;

    entry_state_t            state      [ENTRIES];
    entry_state_t            state_next [ENTRIES];
    logic [OP_WIDTH-1:0]     op         [ENTRIES];
    logic                    a_valid    [ENTRIES];
    logic [31:0]             a_value    [ENTRIES];
    logic [RS_ID_WIDTH-1:0]  a_rs_id    [ENTRIES];
    logic                    b_valid    [ENTRIES];
    logic [31:0]             b_value    [ENTRIES];
    logic [RS_ID_WIDTH-1:0]  b_rs_id    [ENTRIES];

    logic                    lock_valid;
    logic [IDX_W-1:0]        lock_idx;

    logic                    free_found;
    logic [IDX_W-1:0]        free_idx;
    logic                    ready_found;
    logic [IDX_W-1:0]        ready_idx;
    logic [IDX_W-1:0]        sel_idx;
    logic                    do_dispatch;
    logic                    do_issue;
    logic                    a_fwd;
    logic                    b_fwd;

    function automatic logic [RS_ID_WIDTH-1:0] entry_tag(input int idx);
        return RS_ID_WIDTH'(RS_BASE_ID + idx);
    endfunction

    // Reverse scans so the lowest index wins.
    always_comb begin
        free_found  = 1'b0;
        free_idx    = '0;
        ready_found = 1'b0;
        ready_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (state[i] == ST_FREE) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (state[i] == ST_WAITING && a_valid[i] && b_valid[i]) begin
                ready_found = 1'b1;
                ready_idx   = IDX_W'(i);
            end
        end
    end

    assign dispatch_ready = free_found;
    assign dispatch_rs_id = entry_tag(int'(free_idx));
    assign sel_idx        = lock_valid ? lock_idx : ready_idx;
    assign issue_valid    = lock_valid | ready_found;
    assign do_dispatch    = dispatch_valid & dispatch_ready;
    assign do_issue       = issue_valid & issue_ready;
    assign a_fwd          = !dispatch_a_valid && result_valid && (dispatch_a_rs_id == result_rs_id);
    assign b_fwd          = !dispatch_b_valid && result_valid && (dispatch_b_rs_id == result_rs_id);

    // Idle outputs read as zero rather than stale entry contents.
    always_comb begin
        issue_op    = '0;
        issue_a     = '0;
        issue_b     = '0;
        issue_rs_id = '0;
        if (issue_valid) begin
            issue_op    = op[sel_idx];
            issue_a     = a_value[sel_idx];
            issue_b     = b_value[sel_idx];
            issue_rs_id = entry_tag(int'(sel_idx));
        end
    end

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            state_next[i] = state[i];
            case (state[i])
                ST_FREE: begin
                    if (do_dispatch && free_idx == IDX_W'(i))
                        state_next[i] = ST_WAITING;
                end
                ST_WAITING: begin
                    if (do_issue && sel_idx == IDX_W'(i))
                        state_next[i] = ST_ISSUED;
                end
                ST_ISSUED: begin
                    if (result_valid && result_rs_id == entry_tag(i))
                        state_next[i] = ST_FREE;
                end
                default: state_next[i] = ST_FREE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_valid <= 1'b0;
            lock_idx   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                state[i]   <= ST_FREE;
                op[i]      <= '0;
                a_valid[i] <= 1'b0;
                a_value[i] <= '0;
                a_rs_id[i] <= '0;
                b_valid[i] <= 1'b0;
                b_value[i] <= '0;
                b_rs_id[i] <= '0;
            end
        end else begin
            if (do_issue) begin
                lock_valid <= 1'b0;
            end else if (issue_valid) begin
                lock_valid <= 1'b1;
                lock_idx   <= sel_idx;
            end
            for (int i = 0; i < ENTRIES; i++) begin
                state[i] <= state_next[i];
                if (state[i] == ST_WAITING && result_valid) begin
                    if (!a_valid[i] && a_rs_id[i] == result_rs_id) begin
                        a_valid[i] <= 1'b1;
                        a_value[i] <= result_value;
                    end
                    if (!b_valid[i] && b_rs_id[i] == result_rs_id) begin
                        b_valid[i] <= 1'b1;
                        b_value[i] <= result_value;
                    end
                end
                if (do_dispatch && free_idx == IDX_W'(i)) begin
                    op[i]      <= dispatch_op;
                    a_valid[i] <= dispatch_a_valid | a_fwd;
                    a_value[i] <= a_fwd ? result_value : dispatch_a_value;
                    a_rs_id[i] <= dispatch_a_rs_id;
                    b_valid[i] <= dispatch_b_valid | b_fwd;
                    b_value[i] <= b_fwd ? result_value : dispatch_b_value;
                    b_rs_id[i] <= dispatch_b_rs_id;
                end
            end
        end
    end

endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 SHALL have parameter RS_ID_WIDTH, default 5, width of reservation-station tags.
REQ-002 SHALL have parameter ENTRIES, default 3, number of station entries (1..8).
REQ-003 SHALL have parameter RS_BASE_ID, default 0, tag of entry 0; entry i has tag RS_BASE_ID+i, and RS_BASE_ID+ENTRIES SHALL be <= 2**RS_ID_WIDTH.
REQ-004 SHALL have parameter OP_WIDTH, default 6, width of the opaque operation code.
REQ-005 clk  input  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 dispatch_valid  input  1  dispatcher offers an instruction.
REQ-008 dispatch_ready  output  1  a FREE entry exists.
REQ-009 dispatch_op  input  OP_WIDTH  operation code.
REQ-010 dispatch_a_valid / dispatch_b_valid  input  1 each  operand value present (from register-file read port).
REQ-011 dispatch_a_value / dispatch_b_value  input  32 each  operand value.
REQ-012 dispatch_a_rs_id / dispatch_b_rs_id  input  RS_ID_WIDTH each  producing tag when operand not valid.
REQ-013 dispatch_rs_id  output  RS_ID_WIDTH  tag of entry to be allocated; drives register-file update_rs_id.
REQ-014 result_valid  input  1  result broadcast present.
REQ-015 result_rs_id  input  RS_ID_WIDTH  tag of producing station.
REQ-016 result_value  input  32  broadcast result.
REQ-017 issue_valid  output  1  an entry is offered to the execution unit.
REQ-018 issue_ready  input  1  execution unit accepts.
REQ-019 issue_op  output  OP_WIDTH; issue_a / issue_b  output  32 each; issue_rs_id  output  RS_ID_WIDTH.

Function
REQ-020 Each entry SHALL be in one of FREE, WAITING, ISSUED.
REQ-021 dispatch_ready SHALL be 1 iff any entry is FREE at cycle start; dispatch_rs_id SHALL be the tag of the lowest-index FREE entry (combinational).
REQ-022 On dispatch_valid & dispatch_ready the selected entry SHALL go FREE->WAITING next cycle, latching op and both operands (valid, value, rs_id).
REQ-023 Same-cycle forwarding: if a dispatched operand is not valid and result_valid with result_rs_id equal to its rs_id, the entry SHALL latch result_value with operand valid=1.
REQ-024 Every cycle with result_valid, each WAITING entry operand not valid whose rs_id equals result_rs_id SHALL latch result_value and become valid.
REQ-025 A WAITING entry is ready when both operands are valid; selection SHALL pick the lowest-index ready entry.
REQ-026 issue_valid SHALL be 1 when a selection is held or any ready entry exists; outputs show that entry's op, operand values, and tag.
REQ-027 Once issue_valid=1 and issue_ready=0, the selected index SHALL be locked and all issue_* outputs held stable until the handshake.
REQ-028 On issue_valid & issue_ready the entry SHALL go WAITING->ISSUED next cycle and the lock release; at most one issue per cycle.
REQ-029 An ISSUED entry SHALL go to FREE on the cycle after result_valid with result_rs_id equal to its tag; it SHALL NOT be allocatable in the same cycle as that result.
REQ-030 result_rs_id outside [RS_BASE_ID, RS_BASE_ID+ENTRIES-1] SHALL only be snooped per REQ-024, never free entries.
REQ-031 Dispatch, issue, and result capture in the same cycle SHALL all take effect, on distinct entries.
REQ-032 Operand latched values SHALL be exactly 32 bits; tag compare SHALL be full RS_ID_WIDTH equality.

Reset
REQ-033 On rst all entries SHALL become FREE, the issue lock clear, all operand valid bits 0.
REQ-034 After rst: dispatch_ready=1, dispatch_rs_id=RS_BASE_ID, issue_valid=0, issue_* data=0.
REQ-035 rst SHALL override any concurrent dispatch, issue, or result in that cycle.

Verification
REQ-036 Dispatch op=1, a=(1,5), b=(1,7), issue_ready=1 -> next cycle issue_valid=1, issue_a=5, issue_b=7, issue_rs_id=0; then ISSUED; result_rs_id=0 -> entry FREE after one cycle.
REQ-037 Dispatch a waiting on tag 9, b valid; later result_valid, rs_id=9, value=0xDEAD -> issue_valid next cycle with issue_a=0xDEAD.
REQ-038 Dispatch with a waiting on tag 9 in the same cycle as result 9/0x1234 -> entry ready next cycle, issue_a=0x1234.
REQ-039 Fill all 3 entries -> dispatch_ready=0; result for ISSUED tag 1 -> dispatch_ready=1 and dispatch_rs_id=1 only the cycle after.
REQ-040 Entry 2 ready, issue_ready=0, then entry 0 becomes ready -> issue_rs_id stays 2 until the handshake, then entry 0 is issued.
REQ-041 Assert rst with 2 WAITING entries and issue_valid=1 -> next cycle issue_valid=0, dispatch_ready=1, dispatch_rs_id=0.
